// File: rtl/umi_rx_pacer_pkg.sv
// rtl/umi_rx_pacer_pkg.sv - shared types and constants for the UMI receive pacer
package umi_rx_pacer_pkg;

  typedef enum logic [1:0] {
    VM_ALWAYS = 2'd0,
    VM_LFSR   = 2'd1,
    VM_ALT    = 2'd2
  } valid_mode_e;

  // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/umi_rx_pacer_fifo.sv
// rtl/umi_rx_pacer_fifo.sv - synchronous FIFO with wrap-bit pointers and exposed head
module umi_rx_pacer_fifo
  import umi_rx_pacer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     push,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [WIDTH-1:0]         head
);

  localparam int AWD = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AWD:0]     wptr;
  logic [AWD:0]     rptr;
  logic             do_push;
  logic             do_pop;

  // Full is decided from registered pointers only, so a same-cycle pop never frees a slot
  assign full    = (wptr[AWD] != rptr[AWD]) && (wptr[AWD-1:0] == rptr[AWD-1:0]);
  assign empty   = (wptr == rptr);
  assign level   = wptr - rptr;
  assign head    = mem[rptr[AWD-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer update; the extra MSB distinguishes full from empty
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AWD-1:0]] <= push_data;
  end

endmodule

// File: rtl/umi_rx_pacer.sv
// rtl/umi_rx_pacer.sv - buffers UMI packets and paces valid toward the DUT
module umi_rx_pacer
  import umi_rx_pacer_pkg::*;
#(
  parameter int          DW    = 256,
  parameter int          AW    = 64,
  parameter int          CW    = 32,
  parameter int          DEPTH = 4,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             valid_mode,
  input  logic [DW-1:0]          in_data,
  input  logic [AW-1:0]          in_srcaddr,
  input  logic [AW-1:0]          in_dstaddr,
  input  logic [CW-1:0]          in_cmd,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DW-1:0]          data,
  output logic [AW-1:0]          srcaddr,
  output logic [AW-1:0]          dstaddr,
  output logic [CW-1:0]          cmd,
  output logic                   valid,
  input  logic                   ready,
  output logic [$clog2(DEPTH):0] level
);

  localparam int W = DW + 2*AW + CW;

  logic [W-1:0] head;
  logic         full;
  logic         empty;
  logic [15:0]  lfsr;
  logic         toggle;
  logic         hold;
  logic         gate;
  logic         pop;

  umi_rx_pacer_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_data ({in_data, in_srcaddr, in_dstaddr, in_cmd}),
    .push      (in_valid),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .head      (head)
  );

  assign in_ready = !full;
  assign {data, srcaddr, dstaddr, cmd} = head;

  // Per-cycle pacing gate; unused encoding 3 behaves like always
  always_comb begin
    gate = 1'b1;
    case (valid_mode)
      VM_LFSR: gate = lfsr[0];
      VM_ALT:  gate = toggle;
      default: gate = 1'b1;
    endcase
  end

  // A held packet ignores the gate so valid is never retracted before the handshake
  assign valid = !empty && (hold || gate);
  assign pop   = valid && ready;

  // Free-running pacing sources plus the no-retraction hold flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr   <= SEED;
      toggle <= 1'b0;
      hold   <= 1'b0;
    end else begin
      lfsr   <= lfsr_next(lfsr);
      toggle <= ~toggle;
      if (pop)        hold <= 1'b0;
      else if (valid) hold <= 1'b1;
    end
  end

endmodule

// File: tb/tb_umi_rx_pacer.sv
// tb/tb_umi_rx_pacer.sv - self-checking bench for umi_rx_pacer
module tb_umi_rx_pacer;

  localparam int          DW    = 256;
  localparam int          AW    = 64;
  localparam int          CW    = 32;
  localparam int          DEPTH = 4;
  localparam logic [15:0] SEED  = 16'hACE1;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [AW-1:0] s;
    logic [AW-1:0] t;
    logic [CW-1:0] c;
  } pkt_t;

  logic          clk;
  logic          reset;
  logic [1:0]    valid_mode;
  pkt_t          pin;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] data;
  logic [AW-1:0] srcaddr;
  logic [AW-1:0] dstaddr;
  logic [CW-1:0] cmd;
  logic          valid;
  logic          ready;
  logic [2:0]    level;

  int checks = 0;
  int errors = 0;

  umi_rx_pacer #(
    .DW(DW), .AW(AW), .CW(CW), .DEPTH(DEPTH), .SEED(SEED)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_mode (valid_mode),
    .in_data    (pin.d),
    .in_srcaddr (pin.s),
    .in_dstaddr (pin.t),
    .in_cmd     (pin.c),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data       (data),
    .srcaddr    (srcaddr),
    .dstaddr    (dstaddr),
    .cmd        (cmd),
    .valid      (valid),
    .ready      (ready),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: packet queue plus pacing state, advanced at each edge
  pkt_t        q[$];
  logic [15:0] m_lfsr;
  bit          m_tog;
  bit          m_hold;
  bit          m_v;
  bit          m_push;

  function automatic bit exp_valid();
    bit g;
    case (valid_mode)
      2'd1:    g = m_lfsr[0];
      2'd2:    g = m_tog;
      default: g = 1'b1;
    endcase
    return (q.size() != 0) && (m_hold || g);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_lfsr = SEED;
      m_tog  = 1'b0;
      m_hold = 1'b0;
    end else begin
      m_v    = exp_valid();
      m_push = in_valid && (q.size() < DEPTH);
      if (m_v && ready) begin
        void'(q.pop_front());
        m_hold = 1'b0;
      end else if (m_v) begin
        m_hold = 1'b1;
      end
      if (m_push) q.push_back(pin);
      m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
      m_tog  = !m_tog;
    end
  end

  function automatic pkt_t rnd_pkt();
    pkt_t p;
    for (int i = 0; i < DW/32; i++) p.d[i*32 +: 32] = $urandom;
    p.s = {$urandom, $urandom};
    p.t = {$urandom, $urandom};
    p.c = $urandom;
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; ready = 1'b0; valid_mode = 2'd0; pin = '0;
    repeat (2) @(posedge clk);
    settle();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1 reset = 1'b0;
    checks++; if (dut.lfsr !== SEED) begin errors++; $display("FAIL reset_lfsr: got %h want %h", dut.lfsr, SEED); end
  endtask

  task automatic test_back_to_back();
    pkt_t p[3];
    bit   ev;
    for (int i = 0; i < 3; i++) begin
      p[i] = rnd_pkt(); p[i].c = 32'h4; p[i].t = 64'h100;
    end
    valid_mode = 2'd0;
    for (int k = 0; k < 5; k++) begin
      tick();
      ready = 1'b1;
      in_valid = (k < 3);
      if (k < 3) pin = p[k];
      settle();
      ev = (k >= 1) && (k <= 3);
      checks++;
      if (valid !== ev) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want %b", k, valid, ev); end
      if (ev) begin
        checks++;
        if (cmd !== 32'h4 || dstaddr !== 64'h100 || data !== p[k-1].d || srcaddr !== p[k-1].s) begin
          errors++; $display("FAIL b2b_order[%0d]: got src %h want %h", k, srcaddr, p[k-1].s);
        end
      end
    end
    tick(); in_valid = 1'b0; ready = 1'b0;
  endtask

  task automatic test_full();
    pkt_t p[6];
    for (int i = 0; i < 6; i++) p[i] = rnd_pkt();
    valid_mode = 2'd0;
    for (int k = 0; k < 5; k++) begin
      tick();
      ready = 1'b0; in_valid = 1'b1; pin = p[k];
      settle();
      checks++;
      if (in_ready !== (k < 4)) begin errors++; $display("FAIL full_in_ready[%0d]: got %b want %b", k, in_ready, (k < 4)); end
    end
    tick();
    in_valid = 1'b1; pin = p[5]; ready = 1'b1;
    settle();
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_level: got %0d want 4", level); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_pop_no_push: in_ready got %b want 0", in_ready); end
    checks++; if (valid !== 1'b1 || data !== p[0].d) begin errors++; $display("FAIL full_head: valid %b data %h want %h", valid, data, p[0].d); end
    tick();
    in_valid = 1'b0; ready = 1'b0;
    settle();
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL after_pop_level: got %0d want 3", level); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL after_pop_in_ready: got %b want 1", in_ready); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      ready = 1'b1;
      settle();
      checks++;
      if (valid !== 1'b1 || data !== p[k].d) begin errors++; $display("FAIL full_drain[%0d]: got %h want %h", k, data, p[k].d); end
    end
    tick();
    ready = 1'b0;
    settle();
    checks++; if (valid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL full_dropped: valid %b level %0d want 0 0", valid, level); end
  endtask

  task automatic test_simultaneous();
    pkt_t p[3];
    for (int i = 0; i < 3; i++) p[i] = rnd_pkt();
    valid_mode = 2'd0;
    tick(); ready = 1'b0; in_valid = 1'b1; pin = p[0];
    tick(); pin = p[1];
    tick(); pin = p[2]; ready = 1'b1;
    settle();
    checks++; if (level !== 3'd2 || data !== p[0].d) begin errors++; $display("FAIL simul_before: level %0d data %h want 2 %h", level, data, p[0].d); end
    tick(); in_valid = 1'b0; ready = 1'b0;
    settle();
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL simul_level: got %0d want 2", level); end
    checks++; if (data !== p[1].d) begin errors++; $display("FAIL simul_next: got %h want %h", data, p[1].d); end
    tick(); ready = 1'b1;
    tick();
    tick(); ready = 1'b0;
  endtask

  task automatic test_alternate();
    bit v[16];
    int cnt = 0;
    valid_mode = 2'd2;
    for (int k = 0; k < 19; k++) begin
      tick();
      ready = 1'b1; in_valid = 1'b1; pin = rnd_pkt();
      settle();
      if (k >= 3) begin
        v[k-3] = valid;
        checks++;
        if (valid !== exp_valid()) begin errors++; $display("FAIL alt_valid[%0d]: got %b want %b", k, valid, exp_valid()); end
        if (valid) cnt++;
      end
    end
    for (int k = 1; k < 16; k++) begin
      checks++;
      if (v[k] == v[k-1]) begin errors++; $display("FAIL alt_toggle[%0d]: got %b twice", k, v[k]); end
    end
    checks++; if (cnt != 8) begin errors++; $display("FAIL alt_throughput: got %0d want 8", cnt); end
    in_valid = 1'b0; valid_mode = 2'd0;
    for (int k = 0; k < 12 && q.size() != 0; k++) tick();
    checks++; if (q.size() != 0) begin errors++; $display("FAIL alt_drain: %0d left want 0", q.size()); end
    ready = 1'b0;
  endtask

  task automatic test_random();
    int   npush = 0;
    int   npop = 0;
    int   cyc = 0;
    bit   pv = 1'b0;
    bit   pr = 1'b0;
    bit   ev;
    pkt_t pd = '0;
    pkt_t cur;
    valid_mode = 2'd1;
    while (npop < 1000 && cyc < 20000) begin
      tick(); cyc++;
      ready = 1'($urandom_range(0, 1));
      if (npop > 800) valid_mode = 2'($urandom_range(0, 3));
      in_valid = (npush < 1000) && ($urandom_range(0, 3) != 0);
      pin = rnd_pkt();
      settle();
      ev = exp_valid();
      cur = {data, srcaddr, dstaddr, cmd};
      checks++;
      if (valid !== ev || level !== 3'(q.size()) || in_ready !== (q.size() < DEPTH)) begin
        errors++; $display("FAIL rand_ctrl[%0d]: valid %b level %0d in_ready %b want %b %0d %b",
                           cyc, valid, level, in_ready, ev, q.size(), (q.size() < DEPTH));
      end
      if (ev) begin
        checks++;
        if (cur !== q[0]) begin errors++; $display("FAIL rand_payload[%0d]: src %h want %h", cyc, srcaddr, q[0].s); end
      end
      if (pv && !pr) begin
        checks++;
        if (valid !== 1'b1 || cur !== pd) begin errors++; $display("FAIL rand_no_retract[%0d]: valid %b src %h want 1 %h", cyc, valid, srcaddr, pd.s); end
      end
      pv = valid; pr = ready; pd = cur;
      if (ev && ready) npop++;
      if (in_valid && q.size() < DEPTH) npush++;
    end
    checks++; if (npop != 1000) begin errors++; $display("FAIL rand_timeout: popped %0d want 1000", npop); end
    tick(); in_valid = 1'b0; ready = 1'b0; valid_mode = 2'd0;
  endtask

  task automatic test_reset_mid();
    valid_mode = 2'd0;
    for (int k = 0; k < 3; k++) begin
      tick(); ready = 1'b0; in_valid = 1'b1; pin = rnd_pkt();
    end
    tick(); in_valid = 1'b0;
    settle();
    checks++; if (level !== 3'd3 || valid !== 1'b1) begin errors++; $display("FAIL mid_pre: level %0d valid %b want 3 1", level, valid); end
    reset = 1'b1;
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid: got %b want 0", valid); end
    @(posedge clk); #1 reset = 1'b0;
    checks++; if (level !== 3'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_release: level %0d in_ready %b want 0 1", level, in_ready); end
    checks++; if (dut.lfsr !== SEED) begin errors++; $display("FAIL mid_lfsr: got %h want %h", dut.lfsr, SEED); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_full();
    test_simultaneous();
    test_alternate();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
